// File: rtl/rv32_multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// rv32_multicycle_ctrl_if
// Instruction and data memory handshake bundle for the multi-cycle controller.
//   imem_req   : controller -> imem, fetch request
//   imem_ready : imem -> controller, fetch data valid this cycle
//   dmem_req   : controller -> dmem, data access request
//   dmem_we    : controller -> dmem, 1 = store (valid while dmem_req)
//   dmem_ready : dmem -> controller, data access complete this cycle
// master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface rv32_multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        input  imem_ready,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/rv32_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// rv32_multicycle_ctrl
// Control FSM of the multi-cycle RV32I core. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memory,
// aborts to ERROR when a memory stalls for TIMEOUT cycles (0 = never), and
// counts retired instructions.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   mem_if (master)     : imem/dmem request/ready handshake
//   run_i               : execute enable, sampled in IDLE and at retire
//   opcode_i, funct3_i  : instruction fields from the IR
//   alu_zero_i, alu_lt_i: ALU flags used for branch resolution
//   ir_we_o, pc_we_o, pc_src_o, reg_we_o, wb_sel_o : datapath strobes/muxes
//   alu_src_a_o, alu_src_b_o, alu_op_o             : ALU control
//   halted_o, error_o   : sticky status
//   state_o, instret_o  : current state, retired-instruction count
// -----------------------------------------------------------------------------
module rv32_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    rv32_multicycle_ctrl_if.master mem_if,
    input  logic                   run_i,
    input  logic [6:0]             opcode_i,
    input  logic [2:0]             funct3_i,
    input  logic                   alu_zero_i,
    input  logic                   alu_lt_i,
    output logic                   ir_we_o,
    output logic                   pc_we_o,
    output logic [1:0]             pc_src_o,
    output logic                   reg_we_o,
    output logic [1:0]             wb_sel_o,
    output logic                   alu_src_a_o,
    output logic                   alu_src_b_o,
    output logic [1:0]             alu_op_o,
    output logic                   halted_o,
    output logic                   error_o,
    output logic [2:0]             state_o,
    output logic [CNT_W-1:0]       instret_o
);

    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Wait counter only has to reach TIMEOUT-1.
    localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              TO_EN     = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   instret_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               halted_q;
    logic               error_q;

    logic is_load_s, is_store_s, is_branch_s, is_system_s;
    logic legal_s, cond_s, taken_s, timeout_s;
    logic imem_req_s, dmem_req_s, dmem_we_s;

    assign is_load_s   = (opcode_i == OPC_LOAD);
    assign is_store_s  = (opcode_i == OPC_STORE);
    assign is_branch_s = (opcode_i == OPC_BRANCH);
    assign is_system_s = (opcode_i == OPC_SYSTEM);
    // Stall that has already used its last allowed cycle.
    assign timeout_s   = TO_EN && (wait_q == WAIT_LAST);

    // Legal-opcode decode; branch funct3 010/011 have no encoding.
    always_comb begin
        legal_s = 1'b0;
        case (opcode_i)
            OPC_REG, OPC_IMM, OPC_LOAD, OPC_STORE,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal_s = 1'b1;
            OPC_BRANCH: legal_s = (funct3_i[2:1] != 2'b01);
            default:    legal_s = 1'b0;
        endcase
    end

    // Branch resolution: funct3[2] picks eq/lt, funct3[0] inverts the sense.
    always_comb begin
        if (funct3_i[2] == 1'b0) begin
            cond_s = alu_zero_i;
        end else begin
            cond_s = alu_lt_i;
        end
        taken_s = cond_s ^ funct3_i[0];
    end

    // Sequencer: state, wait counter, retire counter and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            // Every entry into FETCH/MEM therefore starts from zero.
            wait_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (run_i) state_q <= S_FETCH;
                    else       state_q <= S_IDLE;
                end
                S_FETCH: begin
                    if (mem_if.imem_ready) begin
                        state_q <= S_DECODE;
                    end else if (timeout_s) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1'b1);
                    end
                end
                S_DECODE: begin
                    if (is_system_s) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (legal_s) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_branch_s) begin
                        instret_q <= instret_q + CNT_W'(1'b1);
                        state_q   <= run_i ? S_FETCH : S_IDLE;
                    end else if (is_load_s || is_store_s) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_if.dmem_ready) begin
                        if (is_store_s) begin
                            instret_q <= instret_q + CNT_W'(1'b1);
                            state_q   <= run_i ? S_FETCH : S_IDLE;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else if (timeout_s) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1'b1);
                    end
                end
                S_WB: begin
                    instret_q <= instret_q + CNT_W'(1'b1);
                    state_q   <= run_i ? S_FETCH : S_IDLE;
                end
                S_HALT:  state_q <= S_HALT;
                S_ERROR: state_q <= S_ERROR;
                default: begin
                    state_q <= S_ERROR;
                    error_q <= 1'b1;
                end
            endcase
        end
    end

    // Strobe decode from the registered state; handshake strobes also see ready.
    always_comb begin
        imem_req_s  = 1'b0;
        dmem_req_s  = 1'b0;
        dmem_we_s   = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_src_o    = 2'b00;
        reg_we_o    = 1'b0;
        wb_sel_o    = 2'b00;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        alu_op_o    = 2'b00;
        case (state_q)
            S_FETCH: begin
                imem_req_s = 1'b1;
                ir_we_o    = mem_if.imem_ready;
            end
            S_EXEC: begin
                case (opcode_i)
                    OPC_LOAD, OPC_STORE, OPC_JALR: alu_src_b_o = 1'b1;
                    OPC_IMM: begin
                        alu_src_b_o = 1'b1;
                        alu_op_o    = 2'b10;
                    end
                    OPC_REG: alu_op_o = 2'b10;
                    OPC_AUIPC: begin
                        alu_src_a_o = 1'b1;
                        alu_src_b_o = 1'b1;
                    end
                    OPC_BRANCH: begin
                        alu_op_o = 2'b01;
                        pc_we_o  = 1'b1;
                        pc_src_o = {1'b0, taken_s};
                    end
                    default: alu_op_o = 2'b00;
                endcase
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = is_store_s;
                pc_we_o    = is_store_s && mem_if.dmem_ready;
            end
            S_WB: begin
                reg_we_o = 1'b1;
                pc_we_o  = 1'b1;
                case (opcode_i)
                    OPC_LOAD: wb_sel_o = 2'd1;
                    OPC_JAL: begin
                        wb_sel_o = 2'd2;
                        pc_src_o = 2'd1;
                    end
                    OPC_JALR: begin
                        wb_sel_o = 2'd2;
                        pc_src_o = 2'd2;
                    end
                    OPC_LUI: wb_sel_o = 2'd3;
                    default: wb_sel_o = 2'd0;
                endcase
            end
            default: imem_req_s = 1'b0;
        endcase
    end

    assign mem_if.imem_req = imem_req_s;
    assign mem_if.dmem_req = dmem_req_s;
    assign mem_if.dmem_we  = dmem_we_s;
    assign halted_o        = halted_q;
    assign error_o         = error_q;
    assign state_o         = state_q;
    assign instret_o       = instret_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv32_multicycle_ctrl
// Stimulus tasks push the expected state/strobe/instret for every cycle into a
// queue while driving inputs; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_rv32_multicycle_ctrl;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
    localparam logic [2:0] ST_MEM  = 3'd4, ST_WB    = 3'd5, ST_HALT   = 3'd6, ST_ERROR = 3'd7;

    typedef struct packed {
        logic       imem_req, ir_we, dmem_req, dmem_we, pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       alu_a, alu_b;
        logic [1:0] alu_op;
        logic       halted, error;
    } strb_t;

    typedef struct packed {
        logic [2:0] st;
        strb_t      sb;
        logic [3:0] ir;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run, alu_zero, alu_lt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       ir_we, pc_we, reg_we, alu_src_a, alu_src_b, halted, error;
    logic [1:0] pc_src, wb_sel, alu_op;
    logic [2:0] state;
    logic [3:0] instret;

    rv32_multicycle_ctrl_if mem_if ();

    rv32_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_if      (mem_if.master),
        .run_i       (run),
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .alu_zero_i  (alu_zero),
        .alu_lt_i    (alu_lt),
        .ir_we_o     (ir_we),
        .pc_we_o     (pc_we),
        .pc_src_o    (pc_src),
        .reg_we_o    (reg_we),
        .wb_sel_o    (wb_sel),
        .alu_src_a_o (alu_src_a),
        .alu_src_b_o (alu_src_b),
        .alu_op_o    (alu_op),
        .halted_o    (halted),
        .error_o     (error),
        .state_o     (state),
        .instret_o   (instret)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    string      cur_tag  = "init";
    logic [3:0] instret_m = 4'd0;
    logic       at_idle   = 1'b1;
    logic [2:0] f3_tab [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every expected cycle record away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  x;
            strb_t o;
            x = exp_q.pop_front();
            o.imem_req = mem_if.imem_req;
            o.ir_we    = ir_we;
            o.dmem_req = mem_if.dmem_req;
            o.dmem_we  = mem_if.dmem_we;
            o.pc_we    = pc_we;
            o.pc_src   = pc_src;
            o.reg_we   = reg_we;
            o.wb_sel   = wb_sel;
            o.alu_a    = alu_src_a;
            o.alu_b    = alu_src_b;
            o.alu_op   = alu_op;
            o.halted   = halted;
            o.error    = error;
            check_eq({cur_tag, ".state"},   {29'd0, state},   {29'd0, x.st});
            check_eq({cur_tag, ".strobes"}, {16'd0, o},       {16'd0, x.sb});
            check_eq({cur_tag, ".instret"}, {28'd0, instret}, {28'd0, x.ir});
        end
    end

    task automatic push_cycle(input logic [2:0] st, input strb_t sb);
        exp_t x;
        x.st = st;
        x.sb = sb;
        x.ir = instret_m;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        instret_m = instret_m + 4'd1;
        if (!run) at_idle = 1'b1;
    endtask

    task automatic do_reset();
        strb_t e;
        rst = 1'b1; run = 1'b0; opcode = 7'd0; funct3 = 3'd0; alu_zero = 1'b0; alu_lt = 1'b0;
        mem_if.imem_ready = 1'b0;
        mem_if.dmem_ready = 1'b0;
        instret_m = 4'd0;
        at_idle = 1'b1;
        cur_tag = "reset";
        e = '0;
        push_cycle(ST_IDLE, e);
        rst = 1'b0;
        push_cycle(ST_IDLE, e);
    endtask

    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input int iwait,
                                input logic run_after);
        strb_t e;
        if (at_idle) begin
            run = 1'b1;
            e = '0;
            push_cycle(ST_IDLE, e);
            at_idle = 1'b0;
        end
        opcode = op;
        funct3 = f3;
        for (int k = 0; k < iwait; k++) begin
            mem_if.imem_ready = 1'b0;
            e = '0; e.imem_req = 1'b1;
            push_cycle(ST_FETCH, e);
        end
        mem_if.imem_ready = 1'b1;
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
        push_cycle(ST_FETCH, e);
        mem_if.imem_ready = 1'b0;
        run = run_after;
        e = '0;
        push_cycle(ST_DECODE, e);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                             input logic lt, input int iwait, input int dwait, input logic run_after);
        strb_t e;
        logic  taken;
        fetch_decode(op, f3, iwait, run_after);
        alu_zero = zero;
        alu_lt   = lt;
        e = '0;
        case (op)
            OP_LOAD, OP_STORE, OP_JALR: e.alu_b = 1'b1;
            OP_IMM:    begin e.alu_b = 1'b1; e.alu_op = 2'b10; end
            OP_REG:    e.alu_op = 2'b10;
            OP_AUIPC:  begin e.alu_a = 1'b1; e.alu_b = 1'b1; end
            OP_BRANCH: e.alu_op = 2'b01;
            default:   e.alu_op = 2'b00;
        endcase
        if (op == OP_BRANCH) begin
            case (f3)
                3'b000:         taken = zero;
                3'b001:         taken = !zero;
                3'b100, 3'b110: taken = lt;
                default:        taken = !lt;
            endcase
            e.pc_we  = 1'b1;
            e.pc_src = {1'b0, taken};
            push_cycle(ST_EXEC, e);
            retire();
        end else begin
            push_cycle(ST_EXEC, e);
            if (op == OP_LOAD || op == OP_STORE) begin
                for (int k = 0; k < dwait; k++) begin
                    mem_if.dmem_ready = 1'b0;
                    e = '0; e.dmem_req = 1'b1; e.dmem_we = (op == OP_STORE);
                    push_cycle(ST_MEM, e);
                end
                mem_if.dmem_ready = 1'b1;
                e = '0; e.dmem_req = 1'b1; e.dmem_we = (op == OP_STORE); e.pc_we = (op == OP_STORE);
                push_cycle(ST_MEM, e);
                mem_if.dmem_ready = 1'b0;
            end
            if (op != OP_STORE) begin
                e = '0; e.reg_we = 1'b1; e.pc_we = 1'b1;
                case (op)
                    OP_LOAD: e.wb_sel = 2'd1;
                    OP_JAL:  begin e.wb_sel = 2'd2; e.pc_src = 2'd1; end
                    OP_JALR: begin e.wb_sel = 2'd2; e.pc_src = 2'd2; end
                    OP_LUI:  e.wb_sel = 2'd3;
                    default: e.wb_sel = 2'd0;
                endcase
                push_cycle(ST_WB, e);
            end
            retire();
        end
    endtask

    // Instruction that ends in a terminal state; inputs wiggle to show it is stuck.
    task automatic run_trap(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] st,
                            input string tag);
        strb_t e;
        cur_tag = tag;
        fetch_decode(op, f3, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run = k[0];
            mem_if.imem_ready = 1'b1;
            mem_if.dmem_ready = 1'b1;
            e = '0; e.halted = (st == ST_HALT); e.error = (st == ST_ERROR);
            push_cycle(st, e);
        end
        do_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        strb_t e;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        cur_tag = "addi";        run_instr(OP_IMM,    3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
        cur_tag = "load_wait";   run_instr(OP_LOAD,   3'b010, 1'b0, 1'b0, 0, 2, 1'b1);
        cur_tag = "bne_taken";   run_instr(OP_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0, 1'b1);
        cur_tag = "bne_not";     run_instr(OP_BRANCH, 3'b001, 1'b1, 1'b0, 0, 0, 1'b1);
        cur_tag = "r_type";      run_instr(OP_REG,    3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
        cur_tag = "lui";         run_instr(OP_LUI,    3'b000, 1'b0, 1'b0, 1, 0, 1'b1);
        cur_tag = "auipc";       run_instr(OP_AUIPC,  3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
        cur_tag = "jal_iwait3";  run_instr(OP_JAL,    3'b000, 1'b0, 1'b0, 3, 0, 1'b1);
        cur_tag = "jalr";        run_instr(OP_JALR,   3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
        cur_tag = "store_stop";  run_instr(OP_STORE,  3'b010, 1'b0, 1'b0, 0, 3, 1'b0);

        cur_tag = "idle_hold";
        e = '0;
        push_cycle(ST_IDLE, e);
        push_cycle(ST_IDLE, e);

        cur_tag = "beq_taken";   run_instr(OP_BRANCH, 3'b000, 1'b1, 1'b0, 0, 0, 1'b1);
        cur_tag = "blt_taken";   run_instr(OP_BRANCH, 3'b100, 1'b0, 1'b1, 0, 0, 1'b1);
        cur_tag = "bgeu_not";    run_instr(OP_BRANCH, 3'b111, 1'b0, 1'b1, 0, 0, 1'b1);

        // Enough retirements to wrap the 4-bit counter.
        cur_tag = "branch_wrap";
        for (int i = 0; i < 14; i++) begin
            run_instr(OP_BRANCH, f3_tab[$urandom_range(5, 0)], 1'($urandom_range(1, 0)),
                      1'($urandom_range(1, 0)), 0, 0, 1'b1);
        end

        run_trap(OP_SYS,     3'b000, ST_HALT,  "ecall");
        run_trap(7'b1111111, 3'b000, ST_ERROR, "illegal_op");
        run_trap(OP_BRANCH,  3'b010, ST_ERROR, "branch_f3_010");
        run_trap(OP_BRANCH,  3'b011, ST_ERROR, "branch_f3_011");

        cur_tag = "imem_timeout";
        run = 1'b1;
        e = '0;
        push_cycle(ST_IDLE, e);
        mem_if.imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = '0; e.imem_req = 1'b1;
            push_cycle(ST_FETCH, e);
        end
        for (int k = 0; k < 3; k++) begin
            mem_if.imem_ready = 1'b1;
            e = '0; e.error = 1'b1;
            push_cycle(ST_ERROR, e);
        end
        do_reset();

        cur_tag = "dmem_timeout";
        fetch_decode(OP_LOAD, 3'b010, 0, 1'b1);
        e = '0; e.alu_b = 1'b1;
        push_cycle(ST_EXEC, e);
        for (int k = 0; k < 4; k++) begin
            e = '0; e.dmem_req = 1'b1;
            push_cycle(ST_MEM, e);
        end
        for (int k = 0; k < 2; k++) begin
            mem_if.dmem_ready = 1'b1;
            e = '0; e.error = 1'b1;
            push_cycle(ST_ERROR, e);
        end
        do_reset();

        cur_tag = "pre_rst_addi"; run_instr(OP_IMM, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1);
        cur_tag = "rst_mid_mem";
        fetch_decode(OP_STORE, 3'b010, 0, 1'b1);
        e = '0; e.alu_b = 1'b1;
        push_cycle(ST_EXEC, e);
        #2;
        check_eq("rst_mid_mem.dmem_req_before", {31'd0, mem_if.dmem_req}, 32'd1);
        check_eq("rst_mid_mem.instret_before",  {28'd0, instret}, {28'd0, instret_m});
        rst = 1'b1;
        #1;
        check_eq("rst_mid_mem.dmem_req", {31'd0, mem_if.dmem_req}, 32'd0);
        check_eq("rst_mid_mem.dmem_we",  {31'd0, mem_if.dmem_we},  32'd0);
        check_eq("rst_mid_mem.state",    {29'd0, state},           32'd0);
        check_eq("rst_mid_mem.instret",  {28'd0, instret},         32'd0);
        @(posedge clk);
        #1;
        do_reset();

        cur_tag = "after_reset"; run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        e = '0;
        push_cycle(ST_IDLE, e);

        check_eq("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
